stim_sig_engine: RTL and testbench

On-chip, parametrised stimulus/response engine for board-level integration checks on the DE2 top level. It drives pseudo-random vectors onto a DUT's switch-style inputs from a seedable 32-bit LFSR and holds each vector for a programmable number of clocks. It compresses the DUT's LED/HEX response into a 32-bit MISR signature, so a full random regression runs in hardware and is judged by a single signature compare.

---
 rtl/stim_sig_engine.sv | 196 +++++++++++++++++++
 tb/tb_stim_sig_engine.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/stim_sig_engine.sv
// Stimulus/response engine: LFSR-driven vectors held for HOLD clocks, DUT response
// compressed into a 32-bit MISR signature.

module stim_sig_engine_chk #(
  parameter int NUM_VEC = 100
) (
  input logic        clk,
  input logic        rst_n,
  input logic        busy,
  input logic        done,
  input logic        stim_valid,
  input logic [15:0] vec_count
);

  localparam logic [15:0] NUM_VEC_C = 16'(NUM_VEC);

  // busy and done are mutually exclusive; a vector is only applied while busy
  a_busy_done_excl: assert property (@(posedge clk) disable iff (!rst_n) !(busy && done));
  a_valid_in_busy:  assert property (@(posedge clk) disable iff (!rst_n) stim_valid |-> busy);
  a_count_bound:    assert property (@(posedge clk) disable iff (!rst_n) vec_count <= NUM_VEC_C);

endmodule

module stim_sig_engine #(
  parameter int          STIM_W  = 18,
  parameter int          RESP_W  = 46,
  parameter int          NUM_VEC = 100,
  parameter int          HOLD    = 1,
  parameter logic [31:0] SEED    = 32'h0000_0001
) (
  input  logic              CLOCK_50,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic              seed_load,
  input  logic [31:0]       seed_in,
  input  logic [RESP_W-1:0] resp_in,
  output logic [STIM_W-1:0] stim_out,
  output logic              stim_valid,
  output logic              busy,
  output logic              done,
  output logic [15:0]       vec_count,
  output logic [31:0]       signature
);

  localparam logic [31:0] POLY      = 32'h8020_0003;
  localparam int          NCHUNK    = (RESP_W + 31) / 32;
  localparam int          PAD_W     = NCHUNK * 32;
  localparam logic [15:0] NUM_VEC_C = 16'(NUM_VEC);
  localparam logic [31:0] HOLD_LAST = 32'(HOLD - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_APPLY  = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  function automatic logic [31:0] lfsr_step(input logic [31:0] x);
    lfsr_step = (x >> 1) ^ (x[0] ? POLY : 32'h0000_0000);
  endfunction

  // Zero-pad the response to whole 32-bit words and XOR the words together
  function automatic logic [31:0] fold_resp(input logic [RESP_W-1:0] r);
    logic [PAD_W-1:0] padded;
    logic [31:0]      acc;
    padded              = {PAD_W{1'b0}};
    padded[RESP_W-1:0]  = r;
    acc                 = 32'h0000_0000;
    for (int j = 0; j < NCHUNK; j++) begin
      acc = acc ^ padded[j*32 +: 32];
    end
    return acc;
  endfunction

  state_t      state_r;
  logic [31:0] seed_r;
  logic [31:0] lfsr_r;
  logic [31:0] sig_r;
  logic [31:0] hold_cnt_r;
  logic [15:0] vec_cnt_r;

  logic [31:0] new_seed_s;
  logic [31:0] seed_next_s;
  logic [31:0] lfsr_next_s;
  logic [31:0] sig_next_s;
  logic [15:0] vec_inc_s;

  // Next-value helpers: sanitised seed, next LFSR/MISR values and incremented count
  always_comb begin
    new_seed_s  = 32'h0000_0000;
    seed_next_s = seed_r;
    if (seed_in == 32'h0000_0000) begin
      new_seed_s = 32'h0000_0001;
    end else begin
      new_seed_s = seed_in;
    end
    if (seed_load) begin
      seed_next_s = new_seed_s;
    end else begin
      seed_next_s = seed_r;
    end
    lfsr_next_s = lfsr_step(lfsr_r);
    sig_next_s  = lfsr_step(sig_r) ^ fold_resp(resp_in);
    vec_inc_s   = vec_cnt_r + 16'd1;
  end

  // Run-control FSM with all datapath state and registered outputs
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= S_IDLE;
      seed_r     <= SEED;
      lfsr_r     <= SEED;
      sig_r      <= 32'h0000_0000;
      hold_cnt_r <= 32'h0000_0000;
      vec_cnt_r  <= 16'h0000;
      stim_out   <= {STIM_W{1'b0}};
      stim_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE, S_DONE: begin
          // A seed loaded together with start is used by that same run
          seed_r <= seed_next_s;
          if (start) begin
            lfsr_r     <= seed_next_s;
            sig_r      <= 32'h0000_0000;
            vec_cnt_r  <= 16'h0000;
            hold_cnt_r <= 32'h0000_0000;
            stim_out   <= seed_next_s[STIM_W-1:0];
            stim_valid <= 1'b1;
            busy       <= 1'b1;
            done       <= 1'b0;
            state_r    <= S_APPLY;
          end
        end
        S_APPLY: begin
          if (abort) begin
            stim_valid <= 1'b0;
            busy       <= 1'b0;
            state_r    <= S_IDLE;
          end else if (hold_cnt_r == HOLD_LAST) begin
            hold_cnt_r <= hold_cnt_r + 32'd1;
            stim_valid <= 1'b0;
            state_r    <= S_SAMPLE;
          end else begin
            hold_cnt_r <= hold_cnt_r + 32'd1;
          end
        end
        S_SAMPLE: begin
          if (abort) begin
            stim_valid <= 1'b0;
            busy       <= 1'b0;
            state_r    <= S_IDLE;
          end else begin
            sig_r      <= sig_next_s;
            lfsr_r     <= lfsr_next_s;
            vec_cnt_r  <= vec_inc_s;
            hold_cnt_r <= 32'h0000_0000;
            if (vec_inc_s == NUM_VEC_C) begin
              busy    <= 1'b0;
              done    <= 1'b1;
              state_r <= S_DONE;
            end else begin
              stim_out   <= lfsr_next_s[STIM_W-1:0];
              stim_valid <= 1'b1;
              state_r    <= S_APPLY;
            end
          end
        end
        default: begin
          stim_valid <= 1'b0;
          busy       <= 1'b0;
          done       <= 1'b0;
          state_r    <= S_IDLE;
        end
      endcase
    end
  end

  assign vec_count = vec_cnt_r;
  assign signature = sig_r;

  stim_sig_engine_chk #(
    .NUM_VEC (NUM_VEC)
  ) u_chk (
    .clk        (CLOCK_50),
    .rst_n      (reset_n),
    .busy       (busy),
    .done       (done),
    .stim_valid (stim_valid),
    .vec_count  (vec_count)
  );

endmodule

// File: tb/tb_stim_sig_engine.sv
// Randomised bench for stim_sig_engine: two parameterisations checked against a
// vector-level reference model of the LFSR sequence and MISR signature.

module tb_stim_sig_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset_n;
  logic         start_t;
  logic         abort_t;
  logic         seed_load_t;
  logic [31:0]  seed_in_t;
  logic [255:0] resp_t;
  int           sel;

  logic start_a, abort_a, load_a;
  logic start_b, abort_b, load_b;
  assign start_a = start_t && (sel == 0);
  assign abort_a = abort_t && (sel == 0);
  assign load_a  = seed_load_t && (sel == 0);
  assign start_b = start_t && (sel == 1);
  assign abort_b = abort_t && (sel == 1);
  assign load_b  = seed_load_t && (sel == 1);

  logic [17:0] stim_a;
  logic        valid_a, busy_a, done_a;
  logic [15:0] vc_a;
  logic [31:0] sig_a;
  logic [6:0]  stim_b;
  logic        valid_b, busy_b, done_b;
  logic [15:0] vc_b;
  logic [31:0] sig_b;

  stim_sig_engine #(
    .STIM_W (18), .RESP_W (46), .NUM_VEC (100), .HOLD (1), .SEED (32'h0000_0001)
  ) dut_a (
    .CLOCK_50 (clk), .reset_n (reset_n), .start (start_a), .abort (abort_a),
    .seed_load (load_a), .seed_in (seed_in_t), .resp_in (resp_t[45:0]),
    .stim_out (stim_a), .stim_valid (valid_a), .busy (busy_a), .done (done_a),
    .vec_count (vc_a), .signature (sig_a)
  );

  stim_sig_engine #(
    .STIM_W (7), .RESP_W (70), .NUM_VEC (5), .HOLD (3), .SEED (32'h0000_ACE1)
  ) dut_b (
    .CLOCK_50 (clk), .reset_n (reset_n), .start (start_b), .abort (abort_b),
    .seed_load (load_b), .seed_in (seed_in_t), .resp_in (resp_t[69:0]),
    .stim_out (stim_b), .stim_valid (valid_b), .busy (busy_b), .done (done_b),
    .vec_count (vc_b), .signature (sig_b)
  );

  logic [31:0] o_stim, o_sig;
  logic [15:0] o_vc;
  logic        o_valid, o_busy, o_done;

  always_comb begin
    if (sel == 1) begin
      o_stim = {25'h0, stim_b}; o_sig = sig_b; o_vc = vc_b;
      o_valid = valid_b; o_busy = busy_b; o_done = done_b;
    end else begin
      o_stim = {14'h0, stim_a}; o_sig = sig_a; o_vc = vc_a;
      o_valid = valid_a; o_busy = busy_a; o_done = done_a;
    end
  end

  int n_chk  = 0;
  int n_pass = 0;
  logic [31:0] seed_m [2];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s (dut %0d, t=%0t): got %h expected %h", tag, sel, $time, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_step(input logic [31:0] x);
    logic [31:0] y;
    y = x / 32'd2;
    if (x % 32'd2 == 32'd1) y = y ^ 32'h8020_0003;
    return y;
  endfunction

  function automatic logic [31:0] m_fold(input logic [255:0] r);
    logic [31:0] acc;
    acc = 32'h0;
    for (int j = 0; j < 8; j++) acc = acc ^ r[j*32 +: 32];
    return acc;
  endfunction

  // mode: 0 random response, 1 all-zero response, 2 constant response of 1
  task automatic run(input int nvec, input int hold, input int stim_w, input int resp_w,
                     input int mode, input int abort_at, input bit load_start,
                     input logic [31:0] load_val, input bit load_busy);
    logic [31:0]  lfsr, sig, smask;
    logic [255:0] r;
    logic [31:0]  vtab [3];
    vtab[0] = 32'h0000_0001; vtab[1] = 32'h0000_0003; vtab[2] = 32'h0000_0002;
    smask = (stim_w >= 32) ? 32'hFFFF_FFFF : ((32'h1 << stim_w) - 32'h1);
    if (load_start) seed_m[sel] = (load_val == 32'h0) ? 32'h1 : load_val;
    lfsr = seed_m[sel];
    sig  = 32'h0;
    start_t = 1'b1; seed_load_t = load_start; seed_in_t = load_val;
    @(negedge clk);
    start_t = 1'b0; seed_load_t = 1'b0;
    for (int k = 0; k < nvec; k++) begin
      r = '0;
      if (mode == 0) begin
        for (int j = 0; j < 8; j++) r[j*32 +: 32] = $urandom;
        for (int i = resp_w; i < 256; i++) r[i] = 1'b0;
      end else if (mode == 2) begin
        r[0] = 1'b1;
      end
      resp_t = r;
      if (k == abort_at) begin
        abort_t = 1'b1;
        @(negedge clk);
        abort_t = 1'b0;
        check_val("abort_valid", {31'h0, o_valid}, 32'h0);
        check_val("abort_busy", {31'h0, o_busy}, 32'h0);
        check_val("abort_done", {31'h0, o_done}, 32'h0);
        check_val("abort_count", {16'h0, o_vc}, k);
        check_val("abort_sig", o_sig, sig);
        return;
      end
      for (int c = 0; c <= hold; c++) begin
        check_val("stim", o_stim, lfsr & smask);
        check_val("stim_valid", {31'h0, o_valid}, (c < hold) ? 32'h1 : 32'h0);
        check_val("busy", {31'h0, o_busy}, 32'h1);
        check_val("done_low", {31'h0, o_done}, 32'h0);
        check_val("vec_count", {16'h0, o_vc}, k);
        check_val("sig_run", o_sig, sig);
        if (mode == 1 && seed_m[sel] == 32'h1 && stim_w == 18 && k < 3)
          check_val("vec_seq", o_stim, vtab[k]);
        if (load_busy && k == 1 && c == 0) begin
          seed_load_t = 1'b1; seed_in_t = $urandom;
        end else begin
          seed_load_t = 1'b0;
        end
        @(negedge clk);
      end
      sig  = m_step(sig) ^ m_fold(r);
      lfsr = m_step(lfsr);
      if (mode == 2 && k == 0) check_val("const_v0", o_sig, 32'h0000_0001);
      if (mode == 2 && k == 1) check_val("const_v1", o_sig, 32'h8020_0002);
    end
    check_val("done", {31'h0, o_done}, 32'h1);
    check_val("done_busy", {31'h0, o_busy}, 32'h0);
    check_val("done_valid", {31'h0, o_valid}, 32'h0);
    check_val("done_count", {16'h0, o_vc}, nvec);
    check_val("done_sig", o_sig, sig);
    if (mode == 1) check_val("zero_sig", o_sig, 32'h0);
    abort_t = 1'b1;
    @(negedge clk);
    abort_t = 1'b0;
    check_val("abort_in_done", {31'h0, o_done}, 32'h1);
    check_val("hold_count", {16'h0, o_vc}, nvec);
    check_val("hold_sig", o_sig, sig);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_stim"}, o_stim, 32'h0);
    check_val({tag, "_valid"}, {31'h0, o_valid}, 32'h0);
    check_val({tag, "_busy"}, {31'h0, o_busy}, 32'h0);
    check_val({tag, "_done"}, {31'h0, o_done}, 32'h0);
    check_val({tag, "_count"}, {16'h0, o_vc}, 32'h0);
    check_val({tag, "_sig"}, o_sig, 32'h0);
  endtask

  initial begin
    reset_n = 1'b0; start_t = 1'b0; abort_t = 1'b0; seed_load_t = 1'b0;
    seed_in_t = 32'h0; resp_t = '0; sel = 0;
    seed_m[0] = 32'h0000_0001;
    seed_m[1] = 32'h0000_ACE1;
    #12;
    sel = 0; #1; check_reset_outputs("rst_a");
    sel = 1; #1; check_reset_outputs("rst_b");
    sel = 0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    run(100, 1, 18, 46, 1, -1, 1'b0, 32'h0, 1'b0);
    run(100, 1, 18, 46, 2, 5, 1'b0, 32'h0, 1'b0);
    run(100, 1, 18, 46, 0, 37, 1'b0, 32'h0, 1'b1);
    run(100, 1, 18, 46, 0, -1, 1'b0, 32'h0, 1'b0);
    run(100, 1, 18, 46, 0, 4, 1'b1, 32'h1234_5679, 1'b0);
    seed_load_t = 1'b1; seed_in_t = 32'h0;
    @(negedge clk);
    seed_load_t = 1'b0;
    seed_m[0] = 32'h0000_0001;
    run(100, 1, 18, 46, 1, 3, 1'b0, 32'h0, 1'b0);

    sel = 1;
    @(negedge clk);
    run(5, 3, 7, 70, 0, -1, 1'b0, 32'h0, 1'b0);
    run(5, 3, 7, 70, 0, -1, 1'b1, $urandom, 1'b1);
    run(5, 3, 7, 70, 0, 2, 1'b0, 32'h0, 1'b0);
    run(5, 3, 7, 70, 2, -1, 1'b0, 32'h0, 1'b0);

    sel = 0;
    seed_load_t = 1'b1; seed_in_t = 32'hDEAD_BEEF;
    @(negedge clk);
    seed_load_t = 1'b0;
    start_t = 1'b1;
    @(negedge clk);
    start_t = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1 check_reset_outputs("rst_mid");
    @(negedge clk);
    reset_n = 1'b1;
    seed_m[0] = 32'h0000_0001;
    seed_m[1] = 32'h0000_ACE1;
    @(negedge clk);
    run(100, 1, 18, 46, 1, 10, 1'b0, 32'h0, 1'b0);
    sel = 1;
    run(5, 3, 7, 70, 0, -1, 1'b0, 32'h0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
